// File: rtl/uart_io_pkg.sv
// Shared constants for the j1 UART peripheral: bus addresses, status layout,
// FSM encodings and the divisor clamp used by both bit timers.
package uart_io_pkg;

  localparam logic [15:0] ADDR_DATA = 16'h1000;
  localparam logic [15:0] ADDR_STAT = 16'h2000;
  localparam logic [15:0] ADDR_DIV  = 16'h4000;
  localparam logic [15:0] DIV_RESET = 16'd104;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  localparam int TX_RDY   = 0;
  localparam int RX_AVAIL = 1;
  localparam int OVF      = 2;
  localparam int FERR     = 3;
  localparam int CNT_LSB  = 4;
  localparam int IRQEN    = 15;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  // A divisor below 2 would make the half-bit wait zero, so clamp it.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; a pop frees a slot for a
// push in the same cycle, so push+pop on a full FIFO both succeed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped UART for the j1 IO bus: register file, TX/RX bit engines,
// 16-entry RX FIFO and a level interrupt while RX data is pending.
module uart_io
  import uart_io_pkg::*;
(
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        interrupt_request
);

  logic sel_data, sel_stat, sel_div;
  logic wr_data, wr_stat, wr_div, rd_pop;

  logic [15:0] div_reg;
  logic [15:0] bit_div;
  logic        irq_en_reg, ovf_reg, ferr_reg, irq_reg;
  logic        ovf_set, ferr_set;

  uart_state_t tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg, hold_reg;
  logic        hold_full_reg, tx_out_reg;

  uart_state_t rx_state_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg, rx_push_reg;

  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign sel_data = (io_addr == ADDR_DATA);
  assign sel_stat = (io_addr == ADDR_STAT);
  assign sel_div  = (io_addr == ADDR_DIV);
  assign wr_data  = io_wr & sel_data;
  assign wr_stat  = io_wr & sel_stat;
  assign wr_div   = io_wr & sel_div;
  assign rd_pop   = io_rd & sel_data & ~fifo_empty;
  assign bit_div  = eff_div(div_reg);

  assign ovf_set  = rx_push_reg & fifo_full & ~rd_pop;
  assign ferr_set = (rx_state_reg == ST_STOP) & (rx_cnt_reg == 16'd0) & ~rx_sync_reg;

  assign uart_tx           = tx_out_reg;
  assign interrupt_request = irq_reg;

  always_comb begin
    io_din = 16'h0000;
    if (sel_data) begin
      io_din = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
    end else if (sel_stat) begin
      io_din[TX_RDY]              = ~hold_full_reg;
      io_din[RX_AVAIL]            = ~fifo_empty;
      io_din[OVF]                 = ovf_reg;
      io_din[FERR]                = ferr_reg;
      io_din[CNT_LSB +: CNT_W]    = fifo_count;
      io_din[IRQEN]               = irq_en_reg;
    end else if (sel_div) begin
      io_din = div_reg;
    end
  end

  // Hardware set is OR'd in after the software clear so it wins a tie.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div_reg    <= DIV_RESET;
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      ferr_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_div)  div_reg    <= io_dout;
      if (wr_stat) irq_en_reg <= io_dout[IRQEN];
      ovf_reg  <= (ovf_reg  & ~(wr_stat & io_dout[OVF]))  | ovf_set;
      ferr_reg <= (ferr_reg & ~(wr_stat & io_dout[FERR])) | ferr_set;
      irq_reg  <= irq_en_reg & ~fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_reg  <= ST_IDLE;
      tx_cnt_reg    <= 16'd0;
      tx_bit_reg    <= 3'd0;
      tx_shift_reg  <= 8'h00;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
      tx_out_reg    <= 1'b1;
    end else begin
      if (wr_data && !hold_full_reg) begin
        hold_reg      <= io_dout[7:0];
        hold_full_reg <= 1'b1;
      end
      case (tx_state_reg)
        ST_IDLE: begin
          tx_out_reg <= 1'b1;
          if (hold_full_reg) begin
            tx_shift_reg  <= hold_reg;
            hold_full_reg <= 1'b0;
            tx_out_reg    <= 1'b0;
            tx_cnt_reg    <= bit_div - 16'd1;
            tx_state_reg  <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_out_reg   <= tx_shift_reg[0];
            tx_bit_reg   <= 3'd0;
            tx_cnt_reg   <= bit_div - 16'd1;
            tx_state_reg <= ST_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_cnt_reg <= bit_div - 16'd1;
            if (tx_bit_reg == 3'd7) begin
              tx_out_reg   <= 1'b1;
              tx_state_reg <= ST_STOP;
            end else begin
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_out_reg   <= tx_shift_reg[1];
              tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: begin
          // Stop bit: chain straight into the next start bit if a byte waits.
          if (tx_cnt_reg == 16'd0) begin
            if (hold_full_reg) begin
              tx_shift_reg  <= hold_reg;
              hold_full_reg <= 1'b0;
              tx_out_reg    <= 1'b0;
              tx_cnt_reg    <= bit_div - 16'd1;
              tx_state_reg  <= ST_START;
            end else begin
              tx_state_reg <= ST_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= ST_IDLE;
      rx_cnt_reg   <= 16'd0;
      rx_bit_reg   <= 3'd0;
      rx_shift_reg <= 8'h00;
      rx_push_reg  <= 1'b0;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      rx_push_reg <= 1'b0;
      case (rx_state_reg)
        ST_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_cnt_reg   <= (bit_div >> 1) - 16'd1;
            rx_state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_reg == 16'd0) begin
            if (!rx_sync_reg) begin
              rx_bit_reg   <= 3'd0;
              rx_cnt_reg   <= bit_div - 16'd1;
              rx_state_reg <= ST_DATA;
            end else begin
              rx_state_reg <= ST_IDLE;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= bit_div - 16'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= ST_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        default: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_push_reg  <= rx_sync_reg;
            rx_state_reg <= ST_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (rx_push_reg),
    .pop    (rd_pop),
    .din    (rx_shift_reg),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io: register vector table, then hand-timed TX, RX,
// overflow, framing, glitch, push/pop and mid-frame reset sequences.
module tb_uart_io;

  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;
  localparam logic [15:0] A_DIV  = 16'h4000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        interrupt_request;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[17];

  logic [79:0] samp;
  logic        start_ok;
  logic [15:0] rdata;

  uart_io dut (
    .clk               (clk),
    .resetq            (resetq),
    .io_rd             (io_rd),
    .io_wr             (io_wr),
    .io_addr           (io_addr),
    .io_dout           (io_dout),
    .io_din            (io_din),
    .uart_rx           (uart_rx),
    .uart_tx           (uart_tx),
    .interrupt_request (interrupt_request)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: got %h", name, act);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  // One frame at 4 clocks per bit, then gap idle clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  initial begin
    int f1_err;
    int f2_err;

    vecs[0]  = '{1'b0, A_STAT,    16'h0000, 16'h0001};
    vecs[1]  = '{1'b0, A_DATA,    16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, A_DIV,     16'h0000, 16'h0068};
    vecs[3]  = '{1'b0, 16'h3000,  16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 16'h1001,  16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, A_DIV,     16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, A_DIV,     16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, A_STAT,    16'h800C, 16'h0000};
    vecs[8]  = '{1'b0, A_STAT,    16'h0000, 16'h8001};
    vecs[9]  = '{1'b1, 16'h1234,  16'hFFFF, 16'h0000};
    vecs[10] = '{1'b0, A_STAT,    16'h0000, 16'h8001};
    vecs[11] = '{1'b0, A_DIV,     16'h0000, 16'h0000};
    vecs[12] = '{1'b1, A_STAT,    16'h7FF0, 16'h0000};
    vecs[13] = '{1'b0, A_STAT,    16'h0000, 16'h0001};
    vecs[14] = '{1'b1, A_DIV,     16'h0004, 16'h0000};
    vecs[15] = '{1'b0, A_DIV,     16'h0000, 16'h0004};
    vecs[16] = '{1'b0, 16'h0000,  16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    check("reset_uart_tx", {15'h0, uart_tx}, 16'h0001);
    check("reset_irq", {15'h0, interrupt_request}, 16'h0000);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
      else            rd_check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // TX: 0x55 then 0xA3 written during the first frame.
    bus_wr(A_DATA, 16'h0155);
    fork
      begin
        start_ok = 1'b0;
        for (int w = 0; w < 4 && !start_ok; w++) begin
          if (uart_tx == 1'b0) start_ok = 1'b1;
          else @(negedge clk);
        end
        if (start_ok) begin
          for (int i = 0; i < 80; i++) begin
            samp[i] = uart_tx;
            @(negedge clk);
          end
        end
      end
      begin
        io_addr = A_STAT; io_rd = 1'b1;
        #1 check("tx_rdy_busy", {15'h0, io_din[0]}, 16'h0000);
        @(negedge clk);
        #1 check("tx_rdy_free", {15'h0, io_din[0]}, 16'h0001);
        io_rd = 1'b0; io_addr = 16'h0000;
        bus_wr(A_DATA, 16'h01A3);
      end
    join
    check("tx_start_seen", {15'h0, start_ok}, 16'h0001);
    f1_err = 0;
    f2_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (samp[i] !== frame_bit(8'h55, i / 4)) f1_err++;
      if (samp[i+40] !== frame_bit(8'hA3, i / 4)) f2_err++;
    end
    check("tx_frame1_bad_samples", 16'(f1_err), 16'h0000);
    check("tx_frame2_bad_samples", 16'(f2_err), 16'h0000);
    repeat (2) @(negedge clk);
    check("tx_idle_high", {15'h0, uart_tx}, 16'h0001);

    // RX and interrupt.
    bus_wr(A_STAT, 16'h8000);
    send_frame(8'hA5, 1'b1, 4);
    rd_check("rx_stat", A_STAT, 16'h8013);
    check("rx_irq_high", {15'h0, interrupt_request}, 16'h0001);
    rd_check("rx_data", A_DATA, 16'h00A5);
    check("rx_irq_still_high", {15'h0, interrupt_request}, 16'h0001);
    @(negedge clk);
    check("rx_irq_low", {15'h0, interrupt_request}, 16'h0000);
    rd_check("rx_stat_empty", A_STAT, 16'h8001);

    // Framing error, then clear it.
    send_frame(8'h3C, 1'b0, 4);
    rd_check("ferr_stat", A_STAT, 16'h8009);
    check("ferr_irq", {15'h0, interrupt_request}, 16'h0000);
    bus_wr(A_STAT, 16'h8008);
    rd_check("ferr_cleared", A_STAT, 16'h8001);

    // One-clock glitch.
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    rd_check("glitch_stat", A_STAT, 16'h8001);

    // Overflow: 17 bytes, 16 kept.
    for (int b = 0; b <= 16; b++) send_frame(8'(b), 1'b1, 4);
    rd_check("ovf_stat", A_STAT, 16'h8107);
    check("ovf_irq", {15'h0, interrupt_request}, 16'h0001);
    for (int b = 0; b < 16; b++) rd_check($sformatf("ovf_rd%0d", b), A_DATA, 16'(b));
    rd_check("ovf_stat_drained", A_STAT, 16'h8005);
    bus_wr(A_STAT, 16'h8004);
    rd_check("ovf_cleared", A_STAT, 16'h8001);

    // Push aligned with a pop on a full FIFO.
    for (int b = 0; b < 16; b++) send_frame(8'h20 + 8'(b), 1'b1, 4);
    rd_check("pp_full_stat", A_STAT, 16'h8103);
    send_frame(8'h77, 1'b1, 0);
    rd_check("pp_pop_head", A_DATA, 16'h0020);
    repeat (3) @(negedge clk);
    rd_check("pp_stat", A_STAT, 16'h8103);
    for (int b = 1; b < 16; b++) rd_check($sformatf("pp_rd%0d", b), A_DATA, 16'h0020 + 16'(b));
    rd_check("pp_last", A_DATA, 16'h0077);
    rd_check("pp_stat_empty", A_STAT, 16'h8001);

    // Reset in the middle of a transmitted frame.
    bus_wr(A_DATA, 16'h0000);
    repeat (6) @(negedge clk);
    check("abort_tx_low", {15'h0, uart_tx}, 16'h0000);
    #2 resetq = 1'b0;
    #1 check("abort_tx_high", {15'h0, uart_tx}, 16'h0001);
    @(negedge clk);
    resetq = 1'b1;
    rd_check("abort_stat", A_STAT, 16'h0001);
    rd_check("abort_div", A_DIV, 16'h0068);
    repeat (4) @(negedge clk);
    check("abort_tx_idle", {15'h0, uart_tx}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_io.md
# uart_io

Memory-mapped UART peripheral on the j1 core's IO bus: `io_rd`, `io_wr`, `io_addr`, `io_dout` and `io_din`, plus a level `interrupt_request`. It serialises bytes written by Forth code, deserialises received bytes into a 16-entry RX FIFO, and raises an interrupt while RX data is pending. `io_din` is zero when the block is not addressed, so several peripherals can be OR-combined in front of the core.

## Interface
- `ADDR_DATA`, 16'h1000, address of the TX/RX data register.
- `ADDR_STAT`, 16'h2000, address of the status/control register.
- `ADDR_DIV`, 16'h4000, address of the baud divisor register.
- `DIV_RESET`, 16'd104, reset divisor in clocks per bit (12 MHz / 115200).
- `FIFO_DEPTH`, 16, RX FIFO entries; must be a power of 2.

Ports:
- `clk`  in  1  clock.
- `resetq`  in  1  reset: asynchronous, active-low.
- `io_rd`  in  1  one-cycle read strobe from the core.
- `io_wr`  in  1  one-cycle write strobe from the core.
- `io_addr`  in  16  register address.
- `io_dout`  in  16  write data.
- `io_din`  out  16  read data; combinational; 0 when the block is not addressed.
- `uart_rx`  in  1  asynchronous serial input.
- `uart_tx`  out  1  serial output; idles high.
- `interrupt_request`  out  1  registered; high while irq_en and the RX FIFO is non-empty.

## Operation
- **Address decode:** exact 16-bit compare against the three addresses. Any other address: no effect, and `io_din` = 0.
- **DATA write:** if TX is ready, load `io_dout[7:0]` into the 1-deep TX holding register. If TX is not ready, the write is dropped silently.
- **DATA read:** `io_din` = {8'h00, FIFO head}, or 0 if the FIFO is empty. The pop happens on the clock edge where `io_rd` is high, the address matches and the FIFO is non-empty.
- **STAT read fields:**
  - bit0: TX ready (holding register empty).
  - bit1: RX FIFO non-empty.
  - bit2: overflow (sticky).
  - bit3: framing error (sticky).
  - bits8:4: FIFO count, 0..16.
  - bit15: irq_en.
  - All other bits read 0.
- **STAT write:** writing 1 to bit2 or bit3 clears that flag; bit15 loads irq_en; all other bits are ignored.
- **DIV read/write:** a plain 16-bit register. The effective divisor is max(DIV, 2).
- **TX FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE with the holding register full: move the byte into the shift register, free the holding register, enter START.
  - Each state lasts one bit time (divisor clocks).
  - DATA shifts 8 bits, LSB first.
  - STOP drives 1.
  - From STOP, go to IDLE, or directly to START if the holding register is full (back-to-back frames).
- **RX path:**
  - `uart_rx` passes through a 2-flop synchroniser.
  - RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on a sync'd falling edge, wait DIV/2 clocks and resample. If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample every DIV clocks, 8 bits, LSB first.
  - STOP: sample once. If low, set framing error and discard the byte; otherwise push the byte.
- **FIFO rules:**
  - Push into a full FIFO with no same-cycle pop: the byte is dropped and overflow is set.
  - Simultaneous push and pop: both succeed, count unchanged, including when full.
- **Flag priority:** if a hardware set and a software clear of the same flag occur in the same cycle, the set wins.
- **Divisor change:** a DIV write mid-frame takes effect at the next bit-counter reload. Frame integrity is not guaranteed.

## Timing
- **Reset values:**
  - `uart_tx`=1, `interrupt_request`=0, `io_din` decodes to 0.
  - FIFO empty, flags 0, irq_en 0, DIV=`DIV_RESET`.
  - Both FSMs in IDLE.
- **Read latency:** zero. `io_din` is valid in the same cycle as `io_rd`, because the core latches it at that edge.
- **Write effect:** at the edge where `io_wr` is high. A read in the next cycle sees the new value.
- **TX latency:** the start bit begins ≤2 clocks after a DATA write to an idle transmitter. A frame is 10 bit times.
- **RX push:** occurs in the cycle after the stop-bit sample. `interrupt_request` rises 1 clock later.
- **Reset mid-frame:** asynchronous abort. `uart_tx` goes high immediately and the partial byte is lost.

## Structure
- Package `uart_io_pkg` holds:
  - the address defaults;
  - status bit indices (TX_RDY=0, RX_AVAIL=1, OVF=2, FERR=3, CNT_LSB=4, IRQEN=15);
  - TX/RX state encodings.
- Sub-module `sync_fifo`: parameterised width/depth; push/pop/full/empty/count; show-ahead head output.
- The TX FSM, RX FSM, synchroniser and register file stay in `uart_io`.

## Test plan
- **Reset state:** reset, then read STAT → 16'h0001, read DATA → 0, `uart_tx`=1.
- **TX frame and back-to-back:**
  - Set DIV=4, write DATA=16'h0155.
  - `uart_tx` must show 0,1,0,1,0,1,0,1,0,1, each held 4 clocks. STAT bit0 must return to 1 one clock after load.
  - A second write during the frame must start immediately after the first frame's stop bit.
- **RX and interrupt:**
  - Set DIV=4, set irq_en (STAT write 16'h8000), drive byte 8'hA5 on `uart_rx`.
  - Required: FIFO count 1, `interrupt_request`=1.
  - Read DATA → 16'h00A5, after which count is 0 and `interrupt_request` goes low 1 clock later.
- **Overflow:**
  - Receive 17 bytes 0x00..0x10 with no reads.
  - Required: count 16, OVF set, reads return 0x00..0x0F in order.
  - Writing STAT=16'h0004 clears OVF.
- **Framing error and glitch:**
  - A frame with a low stop bit sets FERR and does not push.
  - A 1-clock low pulse on `uart_rx` produces no push and no FERR.
- **Simultaneous push/pop:**
  - Align an RX push with a DATA read on a full FIFO.
  - Required: count stays 16, no OVF.
